// File: rtl/prog_pkg.sv
// Shared program-memory definitions: instruction encodings and loader FSM states.
package prog_pkg;

    localparam int unsigned OPC_W = 4;
    localparam int unsigned RSEL_W = 4;
    localparam int unsigned IMM_W = 8;
    localparam int unsigned INSTR_W = OPC_W + RSEL_W + IMM_W;

    // Opcodes occupy the top nibble of an instruction word
    localparam logic [OPC_W-1:0] OP_NOP       = 4'h0;
    localparam logic [OPC_W-1:0] OP_LI        = 4'h1;
    localparam logic [OPC_W-1:0] OP_LOAD      = 4'h2;
    localparam logic [OPC_W-1:0] OP_STORE     = 4'h3;
    localparam logic [OPC_W-1:0] OP_ADD       = 4'h4;
    localparam logic [OPC_W-1:0] OP_SUB       = 4'h5;
    localparam logic [OPC_W-1:0] OP_AND       = 4'h6;
    localparam logic [OPC_W-1:0] OP_OR        = 4'h7;
    localparam logic [OPC_W-1:0] OP_XOR       = 4'h8;
    localparam logic [OPC_W-1:0] OP_NOT       = 4'h9;
    localparam logic [OPC_W-1:0] OP_LIN       = 4'hA;
    localparam logic [OPC_W-1:0] OP_PRINT     = 4'hB;
    localparam logic [OPC_W-1:0] OP_PRINT7SEG = 4'hC;
    localparam logic [OPC_W-1:0] OP_JMP       = 4'hD;

    // Register selects occupy the second nibble
    localparam logic [RSEL_W-1:0] REG_ACCUMULATOR = 4'h0;
    localparam logic [RSEL_W-1:0] REG_A           = 4'h1;
    localparam logic [RSEL_W-1:0] REG_B           = 4'h2;
    localparam logic [RSEL_W-1:0] REG_C           = 4'h3;
    localparam logic [RSEL_W-1:0] REG_D           = 4'h4;
    localparam logic [RSEL_W-1:0] REG_MADDR       = 4'h5;
    localparam logic [RSEL_W-1:0] REG_ZERO        = 4'h6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } prog_state_e;

    // Assemble {opcode, register select, immediate} into one instruction word
    function automatic logic [INSTR_W-1:0] make_instr(
        input logic [OPC_W-1:0]  op,
        input logic [RSEL_W-1:0] rsel,
        input logic [IMM_W-1:0]  imm
    );
        return {op, rsel, imm};
    endfunction

endpackage

// File: rtl/prog_mem_ram.sv
// Simple dual-port program RAM: one write port, one registered read port.
module prog_mem_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: location captured on re_i, word held until the next read
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_loadable.sv
// Run-time loadable program memory: streaming loader, CPU hold and range-checked fetch.
module prog_mem_loadable
    import prog_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_err,
    output logic [ADDR_W:0]   prog_len,
    output logic              cpu_run,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              fetch_oob
);

    localparam int unsigned       LEN_W    = ADDR_W + 1;
    localparam logic [LEN_W-1:0]  LAST_IDX = LEN_W'(DEPTH - 1);

    prog_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]  prog_len_q, prog_len_d;
    logic              load_err_q, load_err_d;
    logic              cpu_run_q;
    logic              fetch_valid_q;
    logic              fetch_oob_q;
    logic              nop_sel_q;

    logic              ram_we;
    logic              fetch_acc;
    logic              fetch_hit;
    logic [DATA_W-1:0] ram_rdata;

    // Next-state, write-pointer and fetch-acceptance logic; load_start overrides everything
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        load_err_d = load_err_q;
        ram_we     = 1'b0;
        fetch_acc  = 1'b0;
        fetch_hit  = ({1'b0, fetch_addr} < prog_len_q);

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (load_valid) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    // Last slot without load_last is forced to terminate the load
                    if (load_last || (LEN_W'(wr_ptr_q) == LAST_IDX)) begin
                        state_d    = ST_RUN;
                        prog_len_d = LEN_W'(wr_ptr_q) + LEN_W'(1);
                        if (!load_last) begin
                            load_err_d = 1'b1;
                        end
                    end
                end
            end
            ST_RUN: begin
                fetch_acc = fetch_req;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_start) begin
            state_d    = ST_LOAD;
            wr_ptr_d   = '0;
            prog_len_d = '0;
            load_err_d = 1'b0;
            ram_we     = 1'b0;
            fetch_acc  = 1'b0;
        end
    end

    // FSM state, load counters and CPU hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            load_err_q <= 1'b0;
            cpu_run_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            load_err_q <= load_err_d;
            cpu_run_q  <= (state_d == ST_RUN);
        end
    end

    // Fetch response flags; oob/NOP select hold between accepted fetches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_q <= 1'b0;
            fetch_oob_q   <= 1'b0;
            nop_sel_q     <= 1'b1;
        end else begin
            fetch_valid_q <= fetch_acc;
            if (fetch_acc) begin
                fetch_oob_q <= !fetch_hit;
                nop_sel_q   <= !fetch_hit;
            end
        end
    end

    prog_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (load_data),
        .re_i    (fetch_acc & fetch_hit),
        .raddr_i (fetch_addr),
        .rdata_o (ram_rdata)
    );

    assign load_ready  = (state_q == ST_LOAD);
    assign load_err    = load_err_q;
    assign prog_len    = prog_len_q;
    assign cpu_run     = cpu_run_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_oob   = fetch_oob_q;
    assign fetch_data  = nop_sel_q ? NOP_WORD : ram_rdata;

endmodule

// File: doc/prog_mem_loadable.md
Name: prog_mem_loadable

Overview:
- Parametrised successor to the fixed, initial-block program ROM.
- Program memory is filled at run time through a streaming loader port instead of at synthesis.
- CPU fetch path keeps registered-address read semantics and adds a valid strobe and out-of-range detection.
- Sits between the boot/UART loader and the processor's fetch stage; holds the CPU while a load is in progress.

Parameters:
- DATA_W, 16, instruction width in bits.
- ADDR_W, 8, program counter width.
- DEPTH, 256, number of words; must satisfy DEPTH <= 2**ADDR_W.
- NOP_WORD, 16'h0000, word returned for out-of-range fetches.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse; begins a new program load.
- load_valid  in  1  load beat valid.
- load_data  in  DATA_W  instruction word for the current beat.
- load_last  in  1  marks the final beat of the program.
- load_ready  out  1  load beat accepted when load_valid & load_ready.
- load_err  out  1  sticky overflow flag.
- prog_len  out  ADDR_W+1  number of valid words loaded.
- cpu_run  out  1  high only in RUN; CPU must stall while low.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  fetch address (PC).
- fetch_data  out  DATA_W  fetched instruction.
- fetch_valid  out  1  fetch_data valid this cycle.
- fetch_oob  out  1  the current fetch was out of range.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, wr_ptr=0, prog_len=0.
  - load_ready=0, load_err=0, cpu_run=0.
  - fetch_valid=0, fetch_oob=0, fetch_data=NOP_WORD.
  - Memory contents are not reset.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: load_start -> LOAD.
  - LOAD: on each accepted beat, mem[wr_ptr]<=load_data and wr_ptr++.
  - LOAD: an accepted beat with load_last -> RUN, prog_len<=wr_ptr+1.
  - RUN: load_start -> LOAD.
- On entry to LOAD (from any state):
  - wr_ptr<=0, prog_len<=0, load_err<=0.
  - An in-flight fetch_valid is still delivered in the following cycle.
- load_start while already in LOAD restarts the load at wr_ptr=0; words already written stay in memory but are not counted.
- load_ready is combinationally high in LOAD and low otherwise; beats outside LOAD are ignored.
- Overflow: an accepted beat at wr_ptr==DEPTH-1 without load_last:
  - The word is written, the beat is treated as last, and the FSM goes to RUN with prog_len=DEPTH.
  - load_err<=1 and stays set until the next load_start.
- Fetch is accepted only when state==RUN and fetch_req=1, sampled at the rising edge.
- Fetch response, one cycle after acceptance:
  - fetch_valid=1.
  - If the registered address < prog_len: fetch_data=mem[addr], fetch_oob=0.
  - Otherwise: fetch_data=NOP_WORD, fetch_oob=1.
- If no fetch was accepted: fetch_valid=0; fetch_data and fetch_oob hold their last values.
- Back-to-back fetches sustain one result per cycle.
- load_start and fetch_req in the same RUN cycle: load wins, the fetch is dropped and no fetch_valid follows.
- Read-during-write cannot occur because fetch is only allowed in RUN.
- cpu_run is registered and equals (state==RUN).
- Reset mid-load returns to IDLE with prog_len=0; the CPU stays held until a complete load.

Decomposition:
- Package prog_pkg:
  - Opcode constants (NOP, LI, LOAD, STORE, ADD, SUB, AND, OR, XOR, NOT, LIN, PRINT, PRINT7SEG, JMP).
  - Register-select constants (ACCUMULATOR, REGA..REGD, MADDR, ZERO).
  - FSM state enum.
- Sub-module prog_mem_ram: simple dual-port RAM with one write port and a registered-address read port, parametrised by DATA_W and DEPTH.
- The top block holds the FSM, counters and fetch logic.

Test Plan:
- Load 3 words (LI|ACC|4 = 0x1004, ADD|REGA = 0x4100, JMP|5 = 0xD005) with load_last on the third -> prog_len=3, cpu_run rises the next cycle, load_err=0.
- In RUN, fetch addresses 0,1,2 back-to-back -> fetch_valid high for 3 cycles, each one cycle after its request, with data 0x1004, 0x4100, 0xD005.
- Fetch address 7 with prog_len=3 -> fetch_data=0x0000, fetch_oob=1, fetch_valid=1.
- Stream DEPTH+2 beats without load_last -> enters RUN after DEPTH beats, prog_len=DEPTH, load_err=1; extra beats see load_ready=0.
- Assert load_start and fetch_req in the same cycle -> no fetch_valid; cpu_run drops and prog_len=0.
- Assert rst_n low mid-load after 2 beats -> all outputs at reset values immediately; a fetch_req while in IDLE produces no fetch_valid.
